// File: rtl/shift_r_seq.sv
// Iterative MIPS32 right shifter (SRL/SRA/SRLV/SRAV): STEP bits per cycle, ceil(SHAMT/STEP) SHIFT cycles, then a one-cycle DONE.
// The shifter accepts a new request only in IDLE; the caller stalls on busy, and a start received while busy is dropped.
module shift_r_seq #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] IN,
  input  logic [4:0]  SHAMT,
  input  logic        ARITH,
  output logic        busy,
  output logic        done,
  output logic [31:0] OUT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t      state_q, state_d;
  logic [31:0] data_q,  data_d;
  logic [31:0] out_q,   out_d;
  logic [4:0]  count_q, count_d;
  logic        fill_q,  fill_d;

  logic [3:0]  k;
  logic [31:0] fill_mask;
  logic [31:0] shifted;
  logic [4:0]  count_nxt;

  // The last step is shortened so the total shift distance is exactly SHAMT.
  always_comb begin
    k         = (count_q < STEP_AMT) ? count_q[3:0] : STEP_AMT[3:0];
    fill_mask = ~(32'hFFFF_FFFF >> k);
    shifted   = (data_q >> k) | (fill_q ? fill_mask : 32'h0);
    count_nxt = count_q - {1'b0, k};
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    fill_d  = fill_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = IN;
          count_d = SHAMT;
          fill_d  = ARITH & IN[31];
          if (SHAMT == 5'd0) begin
            out_d   = IN;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d  = shifted;
        count_d = count_nxt;
        if (count_nxt == 5'd0) begin
          out_d   = shifted;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= 32'h0;
      count_q <= 5'd0;
      fill_q  <= 1'b0;
      out_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign OUT  = out_q;

endmodule

// File: tb/tb_shift_r_seq.sv
// Drives STEP=1/4/8 shifters with identical requests and checks handshake timing and results cycle by cycle.
module tb_shift_r_seq;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in_v;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy_w [NDUT];
  logic        done_w [NDUT];
  logic [31:0] out_w  [NDUT];
  logic [31:0] prev_out [NDUT];

  int checks = 0;
  int errors = 0;

  shift_r_seq #(.STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .IN(in_v), .SHAMT(shamt), .ARITH(arith),
    .busy(busy_w[0]), .done(done_w[0]), .OUT(out_w[0])
  );
  shift_r_seq #(.STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .IN(in_v), .SHAMT(shamt), .ARITH(arith),
    .busy(busy_w[1]), .done(done_w[1]), .OUT(out_w[1])
  );
  shift_r_seq #(.STEP(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .IN(in_v), .SHAMT(shamt), .ARITH(arith),
    .busy(busy_w[2]), .done(done_w[2]), .OUT(out_w[2])
  );

  always #5 clk = ~clk;

  function automatic int step_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int sh, input bit ar);
    logic signed [31:0] s;
    logic [31:0]        u;
    if (ar) begin
      s = v;
      s = s >>> sh;
      return s;
    end
    u = v >> sh;
    return u;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] exp_out);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("%s/s%0d/busy", tag, step_of(i)), 32'(busy_w[i]), 32'd0);
      chk($sformatf("%s/s%0d/done", tag, step_of(i)), 32'(done_w[i]), 32'd0);
      chk($sformatf("%s/s%0d/out",  tag, step_of(i)), out_w[i], exp_out);
    end
  endtask

  // Issues one request; j counts edges after acceptance. A DUT needing n SHIFT
  // cycles must be busy for j<=n, pulse done at j==n and show the result from then on.
  task automatic run_op(input logic [31:0] v, input logic [4:0] sh, input bit ar,
                        input bit inject, input string tag);
    logic [31:0] res;
    int          n [NDUT];
    int          last;
    res = ref_shift(v, int'(sh), ar);
    for (int i = 0; i < NDUT; i++) n[i] = (int'(sh) + step_of(i) - 1) / step_of(i);
    last = n[0] + 1;
    @(negedge clk);
    start = 1'b1; in_v = v; shamt = sh; arith = ar;
    @(posedge clk);
    #1;
    start = inject; in_v = $urandom; shamt = 5'($urandom); arith = ~ar;
    for (int j = 0; j <= last; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        in_v  = $urandom;
      end
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("%s/s%0d/j%0d/busy", tag, step_of(i), j), 32'(busy_w[i]), 32'(j <= n[i]));
        chk($sformatf("%s/s%0d/j%0d/done", tag, step_of(i), j), 32'(done_w[i]), 32'(j == n[i]));
        chk($sformatf("%s/s%0d/j%0d/out",  tag, step_of(i), j), out_w[i],
            (j >= n[i]) ? res : prev_out[i]);
      end
    end
    for (int i = 0; i < NDUT; i++) prev_out[i] = res;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_v = 32'h0; shamt = 5'd0; arith = 1'b0;
    for (int i = 0; i < NDUT; i++) prev_out[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset", 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h8000_0000, 5'd4,  1'b0, 1'b0, "srl4");
    run_op(32'h8000_0000, 5'd4,  1'b1, 1'b0, "sra4_neg");
    run_op(32'h7FFF_FFF0, 5'd4,  1'b1, 1'b0, "sra4_pos");
    run_op(32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, "sh0");
    run_op(32'h8000_0000, 5'd31, 1'b1, 1'b0, "sra31");
    run_op(32'h8000_0000, 5'd31, 1'b0, 1'b0, "srl31");
    run_op(32'h1234_5678, 5'd7,  1'b0, 1'b1, "srl7_inject");
    run_op(32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, "sh0_inject");

    // Abort a request mid-shift: everything clears at once and no done follows.
    @(negedge clk);
    start = 1'b1; in_v = 32'hA5A5_0000; shamt = 5'd20; arith = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("abort_pre/s%0d/busy", step_of(i)), 32'(busy_w[i]), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle("abort_async", 32'h0);
    @(posedge clk);
    #1;
    chk_idle("abort_held", 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1;
      chk_idle($sformatf("abort_quiet%0d", c), 32'h0);
    end
    for (int i = 0; i < NDUT; i++) prev_out[i] = 32'h0;
    run_op(32'hF000_0000, 5'd8, 1'b1, 1'b0, "post_reset");

    for (int r = 0; r < 20; r++)
      run_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", r));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_r_seq.md
Name: shift_r_seq

Overview:
- Multi-cycle right shifter for the MIPS32 datapath.
- Implements SRL/SRA and SRLV/SRAV, complementing the registered left-shift unit used for address and offset scaling.
- Accepts an operand, a shift amount and an arithmetic/logical select with a start pulse. It shifts iteratively, STEP bits per cycle, then presents a registered result with a one-cycle done pulse.
- Sits beside the ALU; the control unit stalls on busy.

Parameters:
STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
IN  input  32  operand (rs/rt value)
SHAMT  input  5  shift amount, 0..31
ARITH  input  1  1 = arithmetic (sign fill, SRA), 0 = logical (zero fill, SRL)
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle pulse; OUT valid from this cycle on
OUT  output  32  registered result; holds until next done

Behaviour:
- Reset (asserted at any time, including mid-operation): state=IDLE, OUT=0, busy=0, done=0, internal data/count/fill cleared. An aborted operation never produces a done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1, load data=IN, count=SHAMT, fill=ARITH&IN[31].
  - If SHAMT==0: go to DONE and load OUT=IN at the same edge.
  - Else: go to SHIFT.
  - With start=0: stay in IDLE.
- SHIFT, each edge:
  - k=min(STEP,count).
  - data shifts right by k; the vacated top k bits take the fill value.
  - count=count-k.
  - If the new count==0: load OUT with the shifted data and go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- Latency: with start sampled at edge E0, the operation takes n=ceil(SHAMT/STEP) SHIFT cycles (n=0 for SHAMT=0). done is high during the cycle following edge E0+n, and the next start is accepted at edge E0+n+2.
- start while busy=1 is ignored; no queuing. IN, SHAMT and ARITH are sampled only at acceptance, so later changes have no effect.
- The sign bit is captured at acceptance and used for every fill step.
- OUT changes only at the edge entering DONE (or at reset). It is stable between operations.
- Result equals IN>>SHAMT (logical) or $signed(IN)>>>SHAMT (arithmetic) for all IN, SHAMT, STEP.

Test Plan:
1. STEP=1, IN=0x80000000, SHAMT=4, ARITH=0 -> done in cycle after E0+4, OUT=0x08000000; busy high 5 cycles.
2. STEP=1, same IN and SHAMT, ARITH=1 -> OUT=0xF8000000. Repeat with IN=0x7FFFFFF0, SHAMT=4 -> OUT=0x07FFFFFF.
3. SHAMT=0, IN=0xDEADBEEF, ARITH=1 -> done in cycle after E0, OUT=0xDEADBEEF, busy high 1 cycle.
4. STEP=1, IN=0x80000000, SHAMT=31: ARITH=1 -> OUT=0xFFFFFFFF after 31 SHIFT cycles; ARITH=0 -> OUT=0x00000001.
5. STEP=4, IN=0x12345678, SHAMT=7, ARITH=0 -> 2 SHIFT cycles (4 then 3), OUT=0x002468AC. Also pulse start with other IN mid-operation -> ignored, result unchanged.
6. Assert rst during SHIFT of any operation -> OUT=0, busy=0 immediately, no done pulse. After release, a new start with IN=0xF0000000, SHAMT=8, ARITH=1 -> OUT=0xFFF00000.
